// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: register offsets, status bit positions and FSM state type
package mmio_uart_pkg;

   localparam logic [31:0] TXDATA_OFFSET = 32'd0;
   localparam logic [31:0] STATUS_OFFSET = 32'd4;

   localparam int FULL_BIT     = 0;
   localparam int EMPTY_BIT    = 1;
   localparam int OVERFLOW_BIT = 2;
   localparam int BUSY_BIT     = 3;
   localparam int COUNT_LSB    = 8;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous byte FIFO; a push while full is taken only alongside a pop
module byte_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [7:0]               push_data,
   input  logic                     pop,
   output logic [7:0]               pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign full     = count_q == (AW+1)'(DEPTH);
   assign empty    = count_q == '0;
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);

   // Storage needs no reset; only valid entries are ever read out
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   // Pointers wrap naturally at DEPTH; count tells full from empty
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with byte FIFO and status register
module mmio_uart_tx
   import mmio_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDRESS   = 32'hFFFF_FF00,
   parameter int          CLOCKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH     = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic        write_memory,
   output logic [31:0] read_data,
   output logic        hit,
   output logic        tx
);

   localparam int CW = $clog2(CLOCKS_PER_BIT);
   localparam int NW = $clog2(FIFO_DEPTH) + 1;

   logic          sel_tx;
   logic          sel_status;
   logic          push_req;
   logic          clear_req;
   logic          pop;
   logic [7:0]    pop_data;
   logic          fifo_full;
   logic          fifo_empty;
   logic [NW-1:0] fifo_count;
   logic          last_tick;
   logic          unused_bits;

   uart_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          overflow_q, overflow_d;

   assign sel_tx      = address == BASE_ADDRESS + TXDATA_OFFSET;
   assign sel_status  = address == BASE_ADDRESS + STATUS_OFFSET;
   assign hit         = sel_tx || sel_status;
   assign push_req    = write_memory && sel_tx;
   assign clear_req   = write_memory && sel_status && write_data[OVERFLOW_BIT];
   assign last_tick   = cnt_q == CW'(CLOCKS_PER_BIT - 1);
   assign tx          = tx_q;
   assign unused_bits = ^write_data[31:8];

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push_req),
      .push_data (write_data[7:0]),
      .pop       (pop),
      .pop_data  (pop_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Status word is visible only at the STATUS address; everything else reads zero
   always_comb begin
      read_data = '0;
      if (sel_status) begin
         read_data[FULL_BIT]          = fifo_full;
         read_data[EMPTY_BIT]         = fifo_empty;
         read_data[OVERFLOW_BIT]      = overflow_q;
         read_data[BUSY_BIT]          = state_q != IDLE;
         read_data[COUNT_LSB +: NW]   = fifo_count;
      end
   end

   // A dropped push sets overflow even when a clear lands on the same edge
   always_comb begin
      overflow_d = (push_req && fifo_full && !pop) ? 1'b1 : clear_req ? 1'b0 : overflow_q;
   end

   // Frame sequencer; the stop bit's last cycle chains straight into the next start bit
   always_comb begin
      state_d = state_q;
      cnt_d   = last_tick ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = pop_data;
               state_d = START;
            end
         end
         START: begin
            if (last_tick) begin
               idx_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (last_tick) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (last_tick) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = pop_data;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
   end

   // Sequencer, line driver and overflow flag registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: randomized scoreboard bench for mmio_uart_tx against a frame-level model
module tb_mmio_uart_tx;

   localparam int          CPB   = 4;
   localparam int          DEPTH = 8;
   localparam logic [31:0] BASE  = 32'hFFFF_FF00;
   localparam logic [31:0] STAT  = BASE + 32'd4;
   localparam int          FLEN  = 10 * CPB;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] address = STAT;
   logic [31:0] write_data = '0;
   logic        write_memory = 1'b0;
   logic [31:0] read_data;
   logic        hit;
   logic        tx;

   int checks = 0;
   int errors = 0;

   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   int         rem = 0;
   logic [7:0] cur = '0;
   logic       m_ovf = 1'b0;
   int         rst_cnt = 0;

   always #5 clock = ~clock;

   mmio_uart_tx #(
      .BASE_ADDRESS   (BASE),
      .CLOCKS_PER_BIT (CPB),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .address      (address),
      .write_data   (write_data),
      .write_memory (write_memory),
      .read_data    (read_data),
      .hit          (hit),
      .tx           (tx)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s = '0;
      s[0] = mq.size() == DEPTH;
      s[1] = mq.size() == 0;
      s[2] = m_ovf;
      s[3] = rem > 0;
      s[8 +: 4] = 4'(mq.size());
      return s;
   endfunction

   function automatic logic model_tx();
      int b;
      if (rem == 0) return 1'b1;
      b = (FLEN - rem) / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return cur[b-1];
   endfunction

   task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rs);
      logic dropped;
      address = a;
      write_data = d;
      write_memory = we;
      reset = rs;
      if (rs) begin
         mq.delete();
         exp_q.delete();
         rem = 0;
         m_ovf = 1'b0;
         rst_cnt++;
      end else begin
         dropped = 1'b0;
         if (rem <= 1 && mq.size() > 0) begin
            cur = mq.pop_front();
            exp_q.push_back(cur);
            rem = FLEN;
         end else if (rem > 0) begin
            rem--;
         end
         if (we && a == BASE) begin
            if (mq.size() < DEPTH) mq.push_back(d[7:0]);
            else dropped = 1'b1;
         end
         m_ovf = dropped ? 1'b1 : (we && a == STAT && d[2]) ? 1'b0 : m_ovf;
      end
      @(posedge clock);
      @(negedge clock);
      check("hit", {31'b0, hit}, {31'b0, (a == BASE || a == STAT)});
      check("read_data", read_data, (a == STAT) ? model_status() : 32'h0);
      check("tx", {31'b0, tx}, {31'b0, model_tx()});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(STAT, 32'h0, 1'b0, 1'b0);
   endtask

   // Monitor: decodes frames off the line and matches them against the expected-byte queue
   logic [7:0] mon_got;
   logic       mon_start;
   logic       mon_stop;
   int         mon_rst;
   initial begin
      forever begin
         @(negedge clock);
         if (tx === 1'b0 && !reset) begin
            mon_rst = rst_cnt;
            repeat (CPB / 2) @(negedge clock);
            mon_start = tx;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clock);
               mon_got[i] = tx;
            end
            repeat (CPB) @(negedge clock);
            mon_stop = tx;
            if (mon_rst == rst_cnt) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL frame: unexpected byte %h on tx, none expected", mon_got);
               end else begin
                  check("frame_byte", {24'b0, mon_got}, {24'b0, exp_q.pop_front()});
                  check("start_bit", {31'b0, mon_start}, 32'h0);
                  check("stop_bit", {31'b0, mon_stop}, 32'h1);
               end
            end
         end
      end
   end

   initial begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) step(STAT, 32'h0, 1'b0, 1'b1);
      check("status_after_reset", read_data, 32'h0000_0002);
      step(32'h0000_0040, 32'h0, 1'b0, 1'b0);
      idle(2);

      step(BASE, 32'h0000_01A5, 1'b1, 1'b0);
      idle(FLEN + 10);

      step(BASE, 32'h55, 1'b1, 1'b0);
      step(BASE, 32'h0F, 1'b1, 1'b0);
      idle(2 * FLEN + 10);

      for (int i = 0; i < 10; i++) step(BASE, 32'(8'hA0 + i), 1'b1, 1'b0);
      idle(1);
      check("overflow_set", read_data & 32'h5, 32'h5);
      step(STAT, 32'h4, 1'b1, 1'b0);
      idle(1);
      check("overflow_cleared", read_data & 32'h4, 32'h0);
      idle(9 * FLEN + 10);

      step(BASE + 32'd8, 32'hFF, 1'b1, 1'b0);
      idle(10);

      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         case ($urandom_range(0, 3))
            0: a = BASE;
            1: a = STAT;
            2: a = BASE + 32'd8;
            default: a = $urandom;
         endcase
         step(a, $urandom, $urandom_range(0, 2) != 0, 1'b0);
      end
      step(STAT, 32'h4, 1'b1, 1'b0);
      idle((DEPTH + 2) * FLEN + 10);
      check("all_frames_seen", 32'(exp_q.size()), 32'h0);

      for (int i = 0; i < 4; i++) step(BASE, 32'(8'h30 + i), 1'b1, 1'b0);
      idle(15);
      step(STAT, 32'h0, 1'b0, 1'b1);
      check("status_mid_reset", read_data, 32'h0000_0002);
      idle(FLEN + 20);
      check("no_frames_after_reset", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
